// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - pipeline execute stage with ALU pass-through and iterative multiplier
//
// Purpose: holds one instruction between decode and memory stages. Non-multiply ops
// return the external ALU result combinationally; multiplies run a 32-cycle
// shift-and-add engine and stall the stage until the product is accepted.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   ds_valid / es_allowin       handshake from decode stage
//   ds_alu_control, ds_src1/2   one-hot op and operands from decode
//   ds_mult, ds_dest, ds_gr_we  multiply flag, destination, write enable
//   es_alu_control, es_alu_src1/2  latched op and operands to the ALU
//   alu_result                  combinational ALU result
//   ms_allowin / es_to_ms_valid handshake to memory stage
//   es_result, es_dest, es_gr_we  instruction payload to memory stage
//   es_busy                     multiplier engine active
module exe_stage #(
    parameter int MUL_EN = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_valid,
    output logic        es_allowin,
    input  logic [11:0] ds_alu_control,
    input  logic [31:0] ds_src1,
    input  logic [31:0] ds_src2,
    input  logic        ds_mult,
    input  logic [4:0]  ds_dest,
    input  logic        ds_gr_we,
    output logic [11:0] es_alu_control,
    output logic [31:0] es_alu_src1,
    output logic [31:0] es_alu_src2,
    input  logic [31:0] alu_result,
    input  logic        ms_allowin,
    output logic        es_to_ms_valid,
    output logic [31:0] es_result,
    output logic [4:0]  es_dest,
    output logic        es_gr_we,
    output logic        es_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic LP_MUL_EN = (MUL_EN != 0);

    state_t      r_state;
    state_t      w_next_state;

    logic        r_es_valid;
    logic [11:0] r_ctrl;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [4:0]  r_dest;
    logic        r_gr_we;
    logic        r_mult;

    logic [31:0] r_product;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [5:0]  r_count;

    logic        w_mult_pending;
    logic        w_ready_go;
    logic        w_load;

    // A latched multiply waits one cycle in IDLE before the engine starts.
    assign w_mult_pending = r_es_valid & r_mult & (r_state == S_IDLE);
    assign w_ready_go     = (r_state == S_DONE) | ((r_state == S_IDLE) & ~w_mult_pending);
    assign es_allowin     = ~r_es_valid | (w_ready_go & ms_allowin);
    assign es_to_ms_valid = r_es_valid & w_ready_go;
    assign w_load         = ds_valid & es_allowin;

    assign es_alu_control = r_ctrl;
    assign es_alu_src1    = r_src1;
    assign es_alu_src2    = r_src2;
    assign es_dest        = r_dest;
    assign es_gr_we       = r_gr_we;
    assign es_busy        = (r_state != S_IDLE);
    assign es_result      = (r_state == S_DONE) ? r_product : alu_result;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_es_valid <= 1'b0;
            r_ctrl     <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
            r_dest     <= '0;
            r_gr_we    <= 1'b0;
            r_mult     <= 1'b0;
        end else begin
            if (es_allowin) begin
                r_es_valid <= ds_valid;
            end
            if (w_load) begin
                r_ctrl  <= ds_alu_control;
                r_src1  <= ds_src1;
                r_src2  <= ds_src2;
                r_dest  <= ds_dest;
                r_gr_we <= ds_gr_we;
                r_mult  <= ds_mult & LP_MUL_EN;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_mult_pending) w_next_state = S_RUN;
            // count holds the number of completed steps; the 32nd step ends RUN
            S_RUN:   if (r_count == 6'd31) w_next_state = S_DONE;
            S_DONE:  if (ms_allowin) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_product <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_count   <= '0;
        end else begin
            if (r_state == S_IDLE && w_mult_pending) begin
                r_product <= '0;
                r_mcand   <= r_src1;
                r_mplier  <= r_src2;
                r_count   <= '0;
            end else if (r_state == S_RUN) begin
                if (r_mplier[0]) begin
                    r_product <= r_product + r_mcand;
                end
                r_mcand  <= {r_mcand[30:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[31:1]};
                r_count  <= r_count + 6'd1;
            end
        end
    end

endmodule
